systolic_tile_ctrl: RTL and testbench

SYSTOLIC_TILE_CTRL -- requirements
Module: systolic_tile_ctrl

---
 rtl/systolic_tile_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_tile_ctrl
//
// Purpose:
//   Sequences one job of num_tiles tiles through an S x S systolic PE array.
//   Each tile runs through the following states:
//     FEED  : K+2S-1 cycles of skewed operand feeding.
//     WRITE : S output rows drained under ofm_ready back-pressure.
//     CLEAR : a single pe_clear cycle, after which both bases step by their
//             strides.
//   After the last tile the block pulses done and returns to IDLE.
//
// Optional feature:
//   TILE_CTRL_PERF_CNT_EN - when defined, perf_cycles counts busy cycles.
//   The count saturates and is cleared on an accepted start. When the macro
//   is undefined, perf_cycles is tied to 0.
//
// Ports:
//   clk, rst                  - clock; asynchronous active-high reset
//   start                     - one-cycle job request (honoured in IDLE only)
//   num_tiles                 - tiles per job (0 runs one tile)
//   ifm_base, ifm_stride      - first IFM address and per-tile increment
//   w_base, w_stride          - first weight address and per-tile increment
//   ofm_ready                 - downstream accepts one OFM row this cycle
//   weight_addr, ifm_addr     - memory read addresses
//   weight_in_valid,
//   ifm_in_valid              - per-lane skewed feed enables
//   psum_down_en              - partial-sum shift-down enable (WRITE)
//   ofm_in_valid              - OFM row valid (WRITE and ofm_ready)
//   pe_clear                  - accumulator clear (CLEAR)
//   busy                      - high in every state except IDLE
//   done                      - one-cycle job completion pulse
//   perf_cycles               - busy-cycle counter (see optional feature)
// ---------------------------------------------------------------------------
module systolic_tile_ctrl #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int K_DEPTH       = 27,
  parameter int W_ADDR_WIDTH  = 9,
  parameter int I_ADDR_WIDTH  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               num_tiles,
  input  logic [I_ADDR_WIDTH-1:0]  ifm_base,
  input  logic [I_ADDR_WIDTH-1:0]  ifm_stride,
  input  logic [W_ADDR_WIDTH-1:0]  w_base,
  input  logic [W_ADDR_WIDTH-1:0]  w_stride,
  input  logic                     ofm_ready,
  output logic [W_ADDR_WIDTH-1:0]  weight_addr,
  output logic [I_ADDR_WIDTH-1:0]  ifm_addr,
  output logic [SYSTOLIC_SIZE-1:0] weight_in_valid,
  output logic [SYSTOLIC_SIZE-1:0] ifm_in_valid,
  output logic                     psum_down_en,
  output logic                     ofm_in_valid,
  output logic                     pe_clear,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              perf_cycles
);

  localparam int S         = SYSTOLIC_SIZE;
  localparam int K         = K_DEPTH;
  localparam int FEED_LAST = K + 2 * S - 2;
  localparam int CW        = $clog2(FEED_LAST + 2);
  localparam int RW        = $clog2(S + 1);

  localparam logic [CW-1:0] FEED_LAST_C = CW'(FEED_LAST);
  localparam logic [CW-1:0] ADDR_LAST_C = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST_C  = RW'(S - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WRITE,
    ST_CLEAR,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           feed_cnt_q, feed_cnt_d;
  logic [RW-1:0]           row_cnt_q, row_cnt_d;
  logic [7:0]              tiles_left_q, tiles_left_d;
  logic [I_ADDR_WIDTH-1:0] ifm_base_q, ifm_base_d;
  logic [I_ADDR_WIDTH-1:0] ifm_stride_q, ifm_stride_d;
  logic [W_ADDR_WIDTH-1:0] w_base_q, w_base_d;
  logic [W_ADDR_WIDTH-1:0] w_stride_q, w_stride_d;

  logic                    in_feed;
  logic [CW-1:0]           feed_off;
  logic [S-1:0]            lane_valid;

  // -------------------------------------------------------------------------
  // State and job registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      feed_cnt_q   <= '0;
      row_cnt_q    <= '0;
      tiles_left_q <= '0;
      ifm_base_q   <= '0;
      ifm_stride_q <= '0;
      w_base_q     <= '0;
      w_stride_q   <= '0;
    end else begin
      state_q      <= state_d;
      feed_cnt_q   <= feed_cnt_d;
      row_cnt_q    <= row_cnt_d;
      tiles_left_q <= tiles_left_d;
      ifm_base_q   <= ifm_base_d;
      ifm_stride_q <= ifm_stride_d;
      w_base_q     <= w_base_d;
      w_stride_q   <= w_stride_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    feed_cnt_d   = feed_cnt_q;
    row_cnt_d    = row_cnt_q;
    tiles_left_d = tiles_left_q;
    ifm_base_d   = ifm_base_q;
    ifm_stride_d = ifm_stride_q;
    w_base_d     = w_base_q;
    w_stride_d   = w_stride_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ifm_base_d   = ifm_base;
          ifm_stride_d = ifm_stride;
          w_base_d     = w_base;
          w_stride_d   = w_stride;
          tiles_left_d = (num_tiles == 8'd0) ? 8'd1 : num_tiles;
          feed_cnt_d   = '0;
          row_cnt_d    = '0;
          state_d      = ST_FEED;
        end
      end

      ST_FEED: begin
        if (feed_cnt_q == FEED_LAST_C) begin
          feed_cnt_d = '0;
          state_d    = ST_WRITE;
        end else begin
          feed_cnt_d = feed_cnt_q + 1'b1;
        end
      end

      ST_WRITE: begin
        // Only rows actually taken by the consumer advance the drain.
        if (ofm_ready) begin
          if (row_cnt_q == ROW_LAST_C) begin
            row_cnt_d = '0;
            state_d   = ST_CLEAR;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        // Bases wrap naturally at their widths.
        ifm_base_d = ifm_base_q + ifm_stride_q;
        w_base_d   = w_base_q + w_stride_q;
        if (tiles_left_q <= 8'd1) begin
          tiles_left_d = 8'd0;
          state_d      = ST_DONE;
        end else begin
          tiles_left_d = tiles_left_q - 8'd1;
          state_d      = ST_FEED;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Feed-side outputs
  // -------------------------------------------------------------------------
  assign in_feed = (state_q == ST_FEED);

  // The address stops at base+K-1 once every operand has been requested.
  // The skew tail then runs off the held address with its valids low.
  assign feed_off = (feed_cnt_q < ADDR_LAST_C) ? feed_cnt_q : ADDR_LAST_C;

  assign ifm_addr    = in_feed ? (ifm_base_q + I_ADDR_WIDTH'(feed_off)) : '0;
  assign weight_addr = in_feed ? (w_base_q + W_ADDR_WIDTH'(feed_off)) : '0;

  // Lane gi sees the data of read t-1 (one-cycle memory latency), delayed by
  // a further gi cycles of skew. It is therefore live for t in [gi+1, gi+K].
  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_lane
      localparam logic [CW-1:0] LANE_LO = CW'(gi + 1);
      localparam logic [CW-1:0] LANE_HI = CW'(gi + K);
      assign lane_valid[gi] = in_feed &&
                              (feed_cnt_q >= LANE_LO) &&
                              (feed_cnt_q <= LANE_HI);
    end
  endgenerate

  assign ifm_in_valid    = lane_valid;
  assign weight_in_valid = lane_valid;

  // -------------------------------------------------------------------------
  // Drain / clear / status outputs
  // -------------------------------------------------------------------------
  assign psum_down_en = (state_q == ST_WRITE);
  assign ofm_in_valid = (state_q == ST_WRITE) && ofm_ready;
  assign pe_clear     = (state_q == ST_CLEAR);
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // Busy-cycle counter
  // -------------------------------------------------------------------------
`ifdef TILE_CTRL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == ST_IDLE) && start) begin
      perf_d = '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_tile_ctrl
//
// Scoreboard bench for systolic_tile_ctrl, with S=4 and K=3.
//
// Each issued job expands into a queue of expected output events, one per
// busy cycle that is not a stall:
//   FEED  - carries addresses and lane valids.
//   ROW   - one accepted OFM row.
//   CLEAR - the pe_clear cycle.
//   DONE  - the done pulse.
// A negedge monitor classifies each DUT cycle, then pops and compares. The
// monitor also checks stall, idle and reset cycles against fixed rules.
// ---------------------------------------------------------------------------
module tb_systolic_tile_ctrl;

  localparam int S      = 4;
  localparam int K      = 3;
  localparam int WA     = 9;
  localparam int IA     = 19;
  localparam int FEED_N = K + 2 * S - 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    num_tiles;
  logic [IA-1:0] ifm_base;
  logic [IA-1:0] ifm_stride;
  logic [WA-1:0] w_base;
  logic [WA-1:0] w_stride;
  logic          ofm_ready;
  logic [WA-1:0] weight_addr;
  logic [IA-1:0] ifm_addr;
  logic [S-1:0]  weight_in_valid;
  logic [S-1:0]  ifm_in_valid;
  logic          psum_down_en;
  logic          ofm_in_valid;
  logic          pe_clear;
  logic          busy;
  logic          done;
  logic [31:0]   perf_cycles;

  systolic_tile_ctrl #(
    .SYSTOLIC_SIZE (S),
    .K_DEPTH       (K),
    .W_ADDR_WIDTH  (WA),
    .I_ADDR_WIDTH  (IA)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_tiles       (num_tiles),
    .ifm_base        (ifm_base),
    .ifm_stride      (ifm_stride),
    .w_base          (w_base),
    .w_stride        (w_stride),
    .ofm_ready       (ofm_ready),
    .weight_addr     (weight_addr),
    .ifm_addr        (ifm_addr),
    .weight_in_valid (weight_in_valid),
    .ifm_in_valid    (ifm_in_valid),
    .psum_down_en    (psum_down_en),
    .ofm_in_valid    (ofm_in_valid),
    .pe_clear        (pe_clear),
    .busy            (busy),
    .done            (done),
    .perf_cycles     (perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order everywhere: {psum_down_en, ofm_in_valid, pe_clear, done, busy}
  localparam logic [4:0] FL_FEED  = 5'b00001;
  localparam logic [4:0] FL_ROW   = 5'b11001;
  localparam logic [4:0] FL_STALL = 5'b10001;
  localparam logic [4:0] FL_CLEAR = 5'b00101;
  localparam logic [4:0] FL_DONE  = 5'b00011;

  typedef struct {
    bit            is_feed;
    logic [4:0]    flags;
    logic [IA-1:0] ia;
    logic [WA-1:0] wa;
    logic [S-1:0]  v;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  rdy_mode    = 0;
  int  stall_left  = 0;

  // Reference model: expands a job into the events the DUT must show.
  task automatic push_job(input int n, input logic [IA-1:0] ib, input logic [IA-1:0] is,
                          input logic [WA-1:0] wb, input logic [WA-1:0] ws);
    int            tiles;
    ev_t           e;
    logic [IA-1:0] cur_i;
    logic [WA-1:0] cur_w;
    tiles = (n == 0) ? 1 : n;
    cur_i = ib;
    cur_w = wb;
    for (int tile = 0; tile < tiles; tile++) begin
      for (int t = 0; t < FEED_N; t++) begin
        int off;
        off       = (t < K) ? t : K - 1;
        e.is_feed = 1'b1;
        e.flags   = FL_FEED;
        e.ia      = cur_i + IA'(off);
        e.wa      = cur_w + WA'(off);
        for (int i = 0; i < S; i++) e.v[i] = (t >= i + 1) && (t <= i + K);
        exp_q.push_back(e);
      end
      e.is_feed = 1'b0;
      e.ia      = '0;
      e.wa      = '0;
      e.v       = '0;
      e.flags   = FL_ROW;
      for (int r = 0; r < S; r++) exp_q.push_back(e);
      e.flags = FL_CLEAR;
      exp_q.push_back(e);
      cur_i = cur_i + is;
      cur_w = cur_w + ws;
    end
    e.flags = FL_DONE;
    exp_q.push_back(e);
  endtask

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ofm_ready = 1'b1;
      1:       ofm_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (stall_left > 0) begin
          ofm_ready  = 1'b0;
          stall_left = stall_left - 1;
        end else begin
          ofm_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor / scoreboard checker.
  logic [4:0] mon_fl;
  ev_t        mon_e;
  always @(negedge clk) begin
    mon_fl = {psum_down_en, ofm_in_valid, pe_clear, done, busy};
    if (rst) begin
      vectors++;
      if (mon_fl != 5'b0 || ifm_in_valid != '0 || weight_in_valid != '0 ||
          ifm_addr != '0 || weight_addr != '0 || perf_cycles != 32'd0) begin
        miscompares++;
        $display("FAIL reset_state: flags=%b iv=%b wv=%b ia=%0d wa=%0d perf=%0d, required all 0",
                 mon_fl, ifm_in_valid, weight_in_valid, ifm_addr, weight_addr, perf_cycles);
      end
    end else if (!busy) begin
      vectors++;
      if (mon_fl != 5'b0 || ifm_in_valid != '0 || weight_in_valid != '0
`ifndef TILE_CTRL_PERF_CNT_EN
          || perf_cycles != 32'd0
`endif
          ) begin
        miscompares++;
        $display("FAIL idle_outputs: flags=%b iv=%b wv=%b perf=%0d, required flags=00000 valids 0",
                 mon_fl, ifm_in_valid, weight_in_valid, perf_cycles);
      end
    end else begin
      if (psum_down_en) begin
        vectors++;
        if (ofm_in_valid !== ofm_ready) begin
          miscompares++;
          $display("FAIL ofm_handshake: ofm_in_valid=%b, required ofm_ready=%b",
                   ofm_in_valid, ofm_ready);
        end
      end
      if (psum_down_en && !ofm_in_valid) begin
        vectors++;
        if (mon_fl != FL_STALL || ifm_in_valid != '0 || weight_in_valid != '0) begin
          miscompares++;
          $display("FAIL write_stall: flags=%b iv=%b wv=%b, required flags=%b valids 0",
                   mon_fl, ifm_in_valid, weight_in_valid, FL_STALL);
        end
      end else begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: flags=%b ia=%0d, required no activity",
                   mon_fl, ifm_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_fl != mon_e.flags || ifm_in_valid != mon_e.v || weight_in_valid != mon_e.v ||
              (mon_e.is_feed && (ifm_addr != mon_e.ia || weight_addr != mon_e.wa))) begin
            miscompares++;
            $display("FAIL event: flags=%b iv=%b wv=%b ia=%0d wa=%0d, required flags=%b v=%b ia=%0d wa=%0d",
                     mon_fl, ifm_in_valid, weight_in_valid, ifm_addr, weight_addr,
                     mon_e.flags, mon_e.v, mon_e.ia, mon_e.wa);
          end
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    exp_q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issues one job and waits (bounded) for its done pulse.
  // mode: 0 ready high, 1 random ready, 2 five-cycle stall after first row.
  task automatic run_job(input int n, input logic [IA-1:0] ib, input logic [IA-1:0] is,
                         input logic [WA-1:0] wb, input logic [WA-1:0] ws,
                         input int mode, input bit poke_start);
    bit got;
    int tiles;
    tiles = (n == 0) ? 1 : n;
    @(posedge clk);
    #1;
    rdy_mode   = mode;
    start      = 1'b1;
    num_tiles  = 8'(n);
    ifm_base   = ib;
    ifm_stride = is;
    w_base     = wb;
    w_stride   = ws;
    push_job(n, ib, is, wb, ws);
    @(posedge clk);
    #1;
    start      = 1'b0;
    num_tiles  = 8'($urandom);
    ifm_base   = IA'($urandom);
    ifm_stride = IA'($urandom);
    w_base     = WA'($urandom);
    w_stride   = WA'($urandom);
    if (poke_start) begin
      repeat (3) @(posedge clk);
      #1;
      start     = 1'b1;
      num_tiles = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (mode == 2) begin
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (psum_down_en) break;
      end
      stall_left = 5;
    end
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL done_timeout: done=0 after 3000 cycles, required done pulse");
      do_reset(2);
    end else begin
      @(posedge clk);
      #1;
`ifdef TILE_CTRL_PERF_CNT_EN
      if (mode != 1) begin
        int exp_perf;
        exp_perf = tiles * (FEED_N + S + 1) + 1 + ((mode == 2) ? 5 : 0);
        vectors++;
        if (perf_cycles != 32'(exp_perf)) begin
          miscompares++;
          $display("FAIL perf_cycles: got %0d, required %0d", perf_cycles, exp_perf);
        end
      end
`endif
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
        exp_q.delete();
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_tiles  = '0;
    ifm_base   = '0;
    ifm_stride = '0;
    w_base     = '0;
    w_stride   = '0;
    ofm_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single tile, ready always high.
    run_job(1, IA'(100), IA'(0), WA'(10), WA'(0), 0, 1'b0);
    // Three tiles with stride 3.
    run_job(3, IA'(100), IA'(3), WA'(10), WA'(3), 0, 1'b0);
    // Five-cycle ready stall in the middle of WRITE.
    run_job(1, IA'(200), IA'(0), WA'(20), WA'(0), 2, 1'b0);
    // Start pulsed during FEED is ignored; num_tiles=0 runs one tile.
    run_job(1, IA'(300), IA'(1), WA'(30), WA'(1), 0, 1'b1);
    run_job(0, IA'(400), IA'(5), WA'(40), WA'(5), 0, 1'b0);
    // Address wrap at both widths.
    run_job(2, IA'(19'h7FFFE), IA'(19'h7FFFF), WA'(9'h1FF), WA'(9'h1FE), 1, 1'b0);

    // Reset in FEED at t=5 abandons the job; outputs drop without a clock.
    @(posedge clk);
    #1;
    rdy_mode  = 0;
    start     = 1'b1;
    num_tiles = 8'd2;
    ifm_base  = IA'(500);
    w_base    = WA'(50);
    push_job(2, IA'(500), ifm_stride, WA'(50), w_stride);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    vectors++;
    if (busy || ifm_in_valid != '0 || weight_in_valid != '0 || ifm_addr != '0 ||
        weight_addr != '0 || psum_down_en || ofm_in_valid || pe_clear || done) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b iv=%b ia=%0d, required all 0 right after rst",
               busy, ifm_in_valid, ifm_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_job(1, IA'(100), IA'(0), WA'(10), WA'(0), 0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 16; j++) begin
      run_job(int'($urandom_range(0, 3)), IA'($urandom), IA'($urandom), WA'($urandom),
              WA'($urandom), int'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
